// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM states, forward-select encodings and the stall/flush control bundle.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int INIT_CYCLES = 2;
    localparam int INIT_CNT_W  = 2;

    typedef struct packed {
        logic stallf;
        logic stalld;
        logic stalle;
        logic stallm;
        logic flushd;
        logic flushe;
        logic flushw;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    localparam ctrl_t CTRL_INIT = '{stallf: 1'b1, stalld: 1'b0, stalle: 1'b0, stallm: 1'b0,
                                    flushd: 1'b1, flushe: 1'b1, flushw: 1'b1};

    localparam ctrl_t CTRL_MEM_WAIT = '{stallf: 1'b1, stalld: 1'b1, stalle: 1'b1, stallm: 1'b1,
                                        flushd: 1'b0, flushe: 1'b0, flushw: 1'b1};

    localparam ctrl_t CTRL_BRANCH = '{stallf: 1'b0, stalld: 1'b0, stalle: 1'b0, stallm: 1'b0,
                                      flushd: 1'b1, flushe: 1'b1, flushw: 1'b0};

    localparam ctrl_t CTRL_LOAD_USE = '{stallf: 1'b1, stalld: 1'b1, stalle: 1'b0, stallm: 1'b0,
                                        flushd: 1'b0, flushe: 1'b1, flushw: 1'b0};

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one ALU source; the memory-stage result
// is younger than the writeback result and therefore wins.
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rdm,
    input  logic [4:0] rdw,
    input  logic       regwritem,
    input  logic       regwritew,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (regwritem && reg_match(rdm, rs)) begin
            fwd_sel = FWD_M;
        end else if (regwritew && reg_match(rdw, rs)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: start-up flush, memory-wait stall, branch
// flush, load-use stall, operand forwarding and saturating perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1d,
    input  logic [4:0]       rs2d,
    input  logic [4:0]       rs1e,
    input  logic [4:0]       rs2e,
    input  logic [4:0]       rde,
    input  logic [4:0]       rdm,
    input  logic [4:0]       rdw,
    input  logic             regwritem,
    input  logic             regwritew,
    input  logic             loade,
    input  logic             pcsrce,
    input  logic             memreqm,
    input  logic             memready,
    output logic             stallf,
    output logic             stalld,
    output logic             stalle,
    output logic             stallm,
    output logic             flushd,
    output logic             flushe,
    output logic             flushw,
    output logic [1:0]       forwardae,
    output logic [1:0]       forwardbe,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             busy
);

    localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                state;
    logic [INIT_CNT_W-1:0] init_cnt;
    ctrl_t                 ctrl;
    logic                  mem_wait;
    logic                  load_use;
    logic                  branch_flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // A pending memory access freezes the whole front of the pipe and bubbles
    // writeback; it outranks any redirect or load-use decided in execute.
    always_comb begin
        mem_wait = ((state == ST_RUN) && memreqm && !memready) ||
                   ((state == ST_MEM_WAIT) && !memready);
        load_use = loade && (reg_match(rde, rs1d) || reg_match(rde, rs2d));
        branch_flush = (state != ST_INIT) && !mem_wait && pcsrce;

        ctrl = CTRL_NONE;
        if (state == ST_INIT) begin
            ctrl = CTRL_INIT;
        end else if (mem_wait) begin
            ctrl = CTRL_MEM_WAIT;
        end else if (pcsrce) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    assign stallf = ctrl.stallf;
    assign stalld = ctrl.stalld;
    assign stalle = ctrl.stalle;
    assign stallm = ctrl.stallm;
    assign flushd = ctrl.flushd;
    assign flushe = ctrl.flushe;
    assign flushw = ctrl.flushw;
    assign busy   = (state != ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (memreqm && !memready) begin
                        state <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (memready) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase

            if ((state != ST_INIT) && ctrl.stallf) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (branch_flush) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

    fwd_unit u_fwd_a (
        .rs        (rs1e),
        .rdm       (rdm),
        .rdw       (rdw),
        .regwritem (regwritem),
        .regwritew (regwritew),
        .fwd_sel   (forwardae)
    );

    fwd_unit u_fwd_b (
        .rs        (rs2e),
        .rdm       (rdm),
        .rdw       (rdw),
        .regwritem (regwritem),
        .regwritew (regwritew),
        .fwd_sel   (forwardbe)
    );

endmodule
